// File: rtl/ram_pkg.sv
// Constants and FSM state type shared by the DDR3 application-port logic.
package ram_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;
    localparam int RAM_ADDR_BITS = 29;
    localparam int RAM_DATA_BITS = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_ISSUE,
        ST_REL
    } wr_state_e;

endpackage

// File: rtl/ram_write_issuer.sv
// Per-client write-burst issuer: packs one address plus two 128-bit FIFO words
// into one 256-bit MIG write and issues up to MAX_BURSTS bursts per grant.
//
// state | meaning
// IDLE  | waiting for the request threshold (or flush with one complete burst)
// REQ   | req high, waiting for grant; burst counter cleared
// F0    | pop address and first data word
// F1    | capture address and word0, pop second data word
// F2    | capture word1, raise app_en and app_wdf_wren
// ISSUE | hold command and data channels until each is accepted
// REL   | drop req, pulse done
module ram_write_issuer
    import ram_pkg::*;
#(
    parameter int unsigned MIN_BURSTS = 4,
    parameter int unsigned MAX_BURSTS = 8
) (
    input  logic                     clk_ram,
    input  logic                     rst,
    output logic                     data_rd_en,
    input  logic [127:0]             data_rd_data,
    input  logic [9:0]               data_rd_size,
    output logic                     addr_rd_en,
    input  logic [RAM_ADDR_BITS-1:0] addr_rd_data,
    input  logic [7:0]               addr_rd_size,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     req,
    input  logic                     grant,
    output logic                     done,
    output logic [RAM_ADDR_BITS-1:0] app_addr,
    output logic [2:0]               app_cmd,
    output logic                     app_en,
    input  logic                     app_rdy,
    output logic [RAM_DATA_BITS-1:0] app_wdf_data,
    output logic [31:0]              app_wdf_mask,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    input  logic                     app_wdf_rdy,
    output logic                     misalign_err,
    output logic [31:0]              burst_count
);

    wr_state_e                  state_q;
    logic [15:0]                n_q;
    logic                       req_q, done_q, flush_done_q;
    logic                       data_rd_en_q, addr_rd_en_q;
    logic                       app_en_q, app_wdf_wren_q;
    logic [RAM_ADDR_BITS-1:0]   app_addr_q;
    logic [RAM_DATA_BITS-1:0]   app_wdf_data_q;
    logic                       misalign_err_q;
    logic [31:0]                burst_count_q;

    logic burst_avail, thresh_met;
    logic app_en_d, app_wdf_wren_d;

    always_comb begin
        burst_avail    = (addr_rd_size != 8'd0) && (data_rd_size >= 10'd2);
        thresh_met     = (32'(addr_rd_size) >= MIN_BURSTS) &&
                         (32'(data_rd_size) >= 2 * MIN_BURSTS);
        // a channel retires in the same cycle its handshake completes
        app_en_d       = app_en_q && !app_rdy;
        app_wdf_wren_d = app_wdf_wren_q && !app_wdf_rdy;
    end

    always_ff @(posedge clk_ram) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            n_q            <= '0;
            req_q          <= 1'b0;
            done_q         <= 1'b0;
            flush_done_q   <= 1'b0;
            data_rd_en_q   <= 1'b0;
            addr_rd_en_q   <= 1'b0;
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            app_addr_q     <= '0;
            app_wdf_data_q <= '0;
            misalign_err_q <= 1'b0;
            burst_count_q  <= '0;
        end else begin
            data_rd_en_q <= 1'b0;
            addr_rd_en_q <= 1'b0;
            done_q       <= 1'b0;
            flush_done_q <= flush && (state_q == ST_IDLE) && !burst_avail;
            case (state_q)
                ST_IDLE: begin
                    if (thresh_met || (flush && burst_avail)) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (grant) begin
                        n_q          <= '0;
                        state_q      <= ST_F0;
                        addr_rd_en_q <= 1'b1;
                        data_rd_en_q <= 1'b1;
                    end
                end
                ST_F0: begin
                    data_rd_en_q <= 1'b1;
                    state_q      <= ST_F1;
                end
                ST_F1: begin
                    app_addr_q <= {addr_rd_data[RAM_ADDR_BITS-1:3], 3'b000};
                    if (addr_rd_data[2:0] != 3'b000) begin
                        misalign_err_q <= 1'b1;
                    end
                    app_wdf_data_q[127:0] <= data_rd_data;
                    state_q               <= ST_F2;
                end
                ST_F2: begin
                    app_wdf_data_q[255:128] <= data_rd_data;
                    app_en_q                <= 1'b1;
                    app_wdf_wren_q          <= 1'b1;
                    state_q                 <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    app_en_q       <= app_en_d;
                    app_wdf_wren_q <= app_wdf_wren_d;
                    if (!app_en_d && !app_wdf_wren_d) begin
                        n_q           <= n_q + 16'd1;
                        burst_count_q <= burst_count_q + 32'd1;
                        if ((32'(n_q) + 32'd1 < MAX_BURSTS) && burst_avail) begin
                            state_q      <= ST_F0;
                            addr_rd_en_q <= 1'b1;
                            data_rd_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_REL;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_REL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_rd_en   = data_rd_en_q;
    assign addr_rd_en   = addr_rd_en_q;
    assign flush_done   = flush_done_q;
    assign req          = req_q;
    assign done         = done_q;
    assign app_addr     = app_addr_q;
    assign app_cmd      = APP_CMD_WRITE;
    assign app_en       = app_en_q;
    assign app_wdf_data = app_wdf_data_q;
    assign app_wdf_mask = 32'd0;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_end  = app_wdf_wren_q;
    assign misalign_err = misalign_err_q;
    assign burst_count  = burst_count_q;

endmodule
